// File: rtl/pmod_bus_responder.sv
// Far-end responder for the micro1 8-bit PMOD bus. It answers four-phase
// address/data handshakes from an internal byte memory and owns the bus enables.
module pmod_bus_responder #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1000
) (
  input  logic        clk_100mhz,
  input  logic        rst_n,
  input  logic        req_in,
  input  logic        we_in,
  input  logic [7:0]  bus_in,
  output logic        ack_out,
  output logic [7:0]  bus_out,
  output logic [7:0]  bus_oe,
  output logic        err,
  output logic [15:0] txn_count
);

  localparam int TMO_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR_ACK  = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_WR_ACK    = 3'd3,
    ST_RD_SETUP  = 3'd4,
    ST_RD_ACK    = 3'd5
  } state_t;

  logic              req_meta_r;
  logic              req_sync_r;
  logic              req_dly_r;
  logic              rise_s;
  logic              fall_s;
  state_t            state_r;
  state_t            state_nxt_s;
  logic [ADDR_W-1:0] addr_r;
  logic              we_r;
  logic [TMO_W-1:0]  tmo_cnt_r;
  logic              ack_r;
  logic [7:0]        bus_out_r;
  logic [7:0]        bus_oe_r;
  logic              err_r;
  logic [15:0]       txn_r;
  logic [7:0]        mem_r [0:(2**ADDR_W)-1];

  logic              latch_s;
  logic              addr_done_s;
  logic              mem_wr_s;
  logic              rd_load_s;
  logic              ack_set_s;
  logic              tmo_hit_s;
  logic              done_s;

  // Request synchronizer; resetting high means a request held through reset is not a rise.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      req_meta_r <= 1'b1;
      req_sync_r <= 1'b1;
      req_dly_r  <= 1'b1;
    end else begin
      req_meta_r <= req_in;
      req_sync_r <= req_meta_r;
      req_dly_r  <= req_sync_r;
    end
  end

  assign rise_s = req_sync_r & ~req_dly_r;
  assign fall_s = ~req_sync_r & req_dly_r;

  // Next-state decode and one-cycle action strobes for the datapath registers.
  always_comb begin
    state_nxt_s = state_r;
    latch_s     = 1'b0;
    addr_done_s = 1'b0;
    mem_wr_s    = 1'b0;
    rd_load_s   = 1'b0;
    ack_set_s   = 1'b0;
    tmo_hit_s   = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rise_s) begin
          latch_s     = 1'b1;
          ack_set_s   = 1'b1;
          state_nxt_s = ST_ADDR_ACK;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ADDR_ACK: begin
        if (fall_s) begin
          addr_done_s = 1'b1;
          state_nxt_s = ST_WAIT_DATA;
        end else begin
          state_nxt_s = ST_ADDR_ACK;
        end
      end
      ST_WAIT_DATA: begin
        if (rise_s) begin
          if (we_r) begin
            mem_wr_s    = 1'b1;
            ack_set_s   = 1'b1;
            state_nxt_s = ST_WR_ACK;
          end else begin
            rd_load_s   = 1'b1;
            state_nxt_s = ST_RD_SETUP;
          end
        end else if (tmo_cnt_r == TMO_W'(TIMEOUT - 1)) begin
          tmo_hit_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_DATA;
        end
      end
      // Read data is already on the bus; ack one cycle later gives it setup time.
      ST_RD_SETUP: begin
        ack_set_s   = 1'b1;
        state_nxt_s = ST_RD_ACK;
      end
      ST_WR_ACK, ST_RD_ACK: begin
        if (fall_s) begin
          done_s      = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, latched transaction context and all registered outputs.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      addr_r    <= {ADDR_W{1'b0}};
      we_r      <= 1'b0;
      tmo_cnt_r <= {TMO_W{1'b0}};
      ack_r     <= 1'b0;
      bus_out_r <= 8'h00;
      bus_oe_r  <= 8'h00;
      err_r     <= 1'b0;
      txn_r     <= 16'h0000;
    end else begin
      state_r <= state_nxt_s;
      if (latch_s) begin
        addr_r <= bus_in[ADDR_W-1:0];
        we_r   <= we_in;
      end
      if (ack_set_s) begin
        ack_r <= 1'b1;
      end else if (addr_done_s || done_s) begin
        ack_r <= 1'b0;
      end
      if (addr_done_s) begin
        tmo_cnt_r <= {TMO_W{1'b0}};
      end else if (state_r == ST_WAIT_DATA) begin
        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
      end
      if (rd_load_s) begin
        bus_out_r <= mem_r[addr_r];
        bus_oe_r  <= 8'hFF;
      end else if (done_s) begin
        bus_oe_r  <= 8'h00;
      end
      if (tmo_hit_s) begin
        err_r <= 1'b1;
      end
      if (done_s) begin
        txn_r <= txn_r + 16'd1;
      end
    end
  end

  // Byte memory; deliberately not reset so contents survive rst_n.
  always_ff @(posedge clk_100mhz) begin
    if (mem_wr_s) begin
      mem_r[addr_r] <= bus_in;
    end
  end

  assign ack_out   = ack_r;
  assign bus_out   = bus_out_r;
  assign bus_oe    = bus_oe_r;
  assign err       = err_r;
  assign txn_count = txn_r;

endmodule

// File: doc/pmod_bus_responder.md
# pmod_bus_responder

Byte-wide bus responder for the far end of the 8-bit bidirectional PMOD bus driven by the `micro1` core. It answers the core's address/data transactions from an internal byte memory, so the core's bus can be exercised on the FPGA without external hardware. The block uses two four-phase req/ack handshakes per transaction and owns the tristate enables for its side of the bus. All initiator-side inputs are treated as asynchronous.

## Interface
- `ADDR_W`, 8: address width; memory depth is 2^ADDR_W bytes. The address is taken from `bus_in[ADDR_W-1:0]`.
- `TIMEOUT`, 1000: maximum number of cycles spent in WAIT_DATA before the transaction is abandoned. Must be ≥ 2.

- `clk_100mhz` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_in` in 1: initiator request, asynchronous.
- `we_in` in 1: 1 = write transaction; sampled during the address phase only.
- `bus_in` in 8: bus value as seen at the pins.
- `ack_out` out 1: responder acknowledge.
- `bus_out` out 8: read data driven to the bus.
- `bus_oe` out 8: per-bit output enable; the value is always 8'h00 or 8'hFF.
- `err` out 1: sticky timeout flag.
- `txn_count` out 16: completed-transaction counter; wraps modulo 2^16.

## Operation
- **Synchronizer.** `req_in` passes through a 2-flop synchronizer to give `req_s`; `req_d` is `req_s` delayed by one cycle.
  - Rise = `req_s & ~req_d`; fall = `~req_s & req_d`.
  - All three flops reset to 1, so a `req_in` held high through reset produces no rise.
  - A fall seen in IDLE is ignored.
- **Bus sampling.** `bus_in` and `we_in` are sampled raw, unsynchronized, in the cycle a rise is detected. The initiator holds them stable from before raising `req_in` until it sees `ack_out`.
- **FSM states:** IDLE, ADDR_ACK, WAIT_DATA, WR_ACK, RD_SETUP, RD_ACK.
  - IDLE, on rise: latch addr and we, set `ack_out`=1, go to ADDR_ACK.
  - ADDR_ACK, on fall: set `ack_out`=0, clear the timeout counter, go to WAIT_DATA.
  - WAIT_DATA, on rise with we=1: write `mem[addr] <= bus_in`, set `ack_out`=1, go to WR_ACK.
  - WAIT_DATA, on rise with we=0: set `bus_out` <= `mem[addr]` and `bus_oe` <= 8'hFF, go to RD_SETUP.
  - WAIT_DATA, timeout: the counter increments each cycle; when it reaches TIMEOUT-1 with no rise, set `err`=1 and go to IDLE.
  - RD_SETUP: unconditionally set `ack_out`=1 and go to RD_ACK. This gives one cycle of data setup before ack.
  - WR_ACK or RD_ACK, on fall: in the same edge set `ack_out`=0, `bus_oe`=8'h00, and `txn_count`+1; go to IDLE. `bus_out` holds its last value.
- **Bus contention rule.** `bus_oe` is nonzero only in RD_SETUP and RD_ACK. The initiator must tristate the bus from the read data-phase request until it sees `ack_out` low.
- **Memory.** The memory is not reset; its contents are undefined after configuration.
- **Error flag.** `err` is cleared only by `rst_n`.
- **Reset mid-operation.** All outputs go to their reset values asynchronously, including `bus_oe`=0 and `ack_out`=0. The FSM returns to IDLE and memory contents are kept. Any in-flight transaction is lost.
- **Reset values:**
  - `ack_out`=0, `bus_out`=8'h00, `bus_oe`=8'h00, `err`=0, `txn_count`=0.
  - FSM in IDLE, addr=0, we=0, timeout counter=0.

## Timing
- A `req_in` edge is recognised as a rise or fall on the 3rd clock edge after the pin changes: two synchronizer edges plus the edge that updates `req_d`.
- `ack_out` rises 1 cycle after a detected rise in the IDLE and WAIT_DATA(write) paths. It rises 2 cycles after in the read data path, because of RD_SETUP.
- `ack_out` falls 1 cycle after a detected fall.
- On a read, `bus_out` and `bus_oe` are valid exactly one cycle before `ack_out` rises. They are released in the same edge that drops `ack_out`.
- Minimum full transaction is about 16 cycles when the initiator reacts within one cycle.

## Test plan
- **Write then read.** Address phase 8'h12 with we=1, then data phase 8'hA5; next, address phase 8'h12 with we=0, then a read data phase. Required: `bus_out`=8'hA5 with `bus_oe`=8'hFF one cycle before `ack_out` rises, and `txn_count`=2.
- **Top address.** Write 8'h3C to address 8'hFF, then read address 8'hFF. Required: 8'h3C returned, and address 8'h00 unchanged.
- **Timeout.** Complete an address phase, then hold `req_in` low for TIMEOUT cycles. Required: `err`=1 at cycle TIMEOUT after entering WAIT_DATA, FSM in IDLE, `txn_count` unchanged. A following full transaction still succeeds with `err` still 1.
- **Reset during a read.** Assert `rst_n`=0 while in RD_ACK. Required: `bus_oe`=0 and `ack_out`=0 immediately, without waiting for a clock edge. After release, a new transaction works and previously written memory data is intact.
- **Request held through reset.** Hold `req_in`=1 across reset release for 10 cycles. Required: `ack_out` stays 0; the first genuine low→high on `req_in` starts an address phase.
- **Slow initiator.** Insert 50-cycle gaps between every `req_in` edge, with TIMEOUT greater than 50. Required: identical data results and no `err`.
